noc_credit_link_pipeline: RTL and testbench

//  Multi-lane, credit-based router-to-router link: NUM_PIPELINE register stages on the forward flit

---
 rtl/noc_credit_link_pipeline.sv | 170 +++++++++++++++++
 tb/tb_noc_credit_link_pipeline.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_link_pipeline.sv
// Multi-lane credit-based router-to-router link with per-lane outstanding-credit tracking.
// Optional per-lane flit/packet statistics are enabled by defining NOC_LINK_STATS_EN.
module noc_credit_link_pipeline #(
    parameter int unsigned NUM_LINKS         = 4,
    parameter int unsigned FLIT_WIDTH        = 64,
    parameter int unsigned DEST_WIDTH        = 6,
    parameter int unsigned NUM_PIPELINE      = 1,
    parameter int unsigned FLIT_BUFFER_DEPTH = 4,
    parameter int unsigned CNT_W             = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                  clk_noc,
    input  logic                                  rst_noc_sync,
    input  logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]  data_in,
    input  logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]  dest_in,
    input  logic [NUM_LINKS-1:0]                  is_tail_in,
    input  logic [NUM_LINKS-1:0]                  send_in,
    output logic [NUM_LINKS-1:0]                  credit_out,
    output logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]  data_out,
    output logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]  dest_out,
    output logic [NUM_LINKS-1:0]                  is_tail_out,
    output logic [NUM_LINKS-1:0]                  send_out,
    input  logic [NUM_LINKS-1:0]                  credit_in,
`ifdef NOC_LINK_STATS_EN
    input  logic                                  stats_clear,
    output logic [NUM_LINKS-1:0][31:0]            flit_count,
    output logic [NUM_LINKS-1:0][31:0]            pkt_count,
`endif
    output logic [NUM_LINKS-1:0][CNT_W-1:0]       outstanding,
    output logic [NUM_LINKS-1:0]                  err_overflow,
    output logic [NUM_LINKS-1:0]                  err_underflow
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(FLIT_BUFFER_DEPTH);

    // ------------------------------------------------------------------
    // Forward and backward delay lines
    // ------------------------------------------------------------------
    if (NUM_PIPELINE == 0) begin : g_bypass
        assign data_out    = data_in;
        assign dest_out    = dest_in;
        assign is_tail_out = is_tail_in;
        assign send_out    = send_in;
        assign credit_out  = credit_in;
    end else begin : g_pipe
        logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0][FLIT_WIDTH-1:0] data_q;
        logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0][DEST_WIDTH-1:0] dest_q;
        logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 tail_q;
        logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 send_q;
        logic [NUM_PIPELINE-1:0][NUM_LINKS-1:0]                 credit_q;

        // Stage 0 captures the inputs; each later stage copies its predecessor.
        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                data_q   <= '0;
                dest_q   <= '0;
                tail_q   <= '0;
                send_q   <= '0;
                credit_q <= '0;
            end else begin
                data_q[0]   <= data_in;
                dest_q[0]   <= dest_in;
                tail_q[0]   <= is_tail_in;
                send_q[0]   <= send_in;
                credit_q[0] <= credit_in;
                for (int unsigned s = 1; s < NUM_PIPELINE; s++) begin
                    data_q[s]   <= data_q[s-1];
                    dest_q[s]   <= dest_q[s-1];
                    tail_q[s]   <= tail_q[s-1];
                    send_q[s]   <= send_q[s-1];
                    credit_q[s] <= credit_q[s-1];
                end
            end
        end

        assign data_out    = data_q[NUM_PIPELINE-1];
        assign dest_out    = dest_q[NUM_PIPELINE-1];
        assign is_tail_out = tail_q[NUM_PIPELINE-1];
        assign send_out    = send_q[NUM_PIPELINE-1];
        assign credit_out  = credit_q[NUM_PIPELINE-1];
    end

    // ------------------------------------------------------------------
    // Outstanding-credit counters and sticky protocol error flags
    // ------------------------------------------------------------------
    logic [NUM_LINKS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_LINKS-1:0]            ovf_q, ovf_d;
    logic [NUM_LINKS-1:0]            unf_q, unf_d;

    // Counted from the upstream side: a flit leaves on send_in, a credit arrives on credit_out.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        for (int unsigned l = 0; l < NUM_LINKS; l++) begin
            unique case ({send_in[l], credit_out[l]})
                2'b10: begin
                    if (cnt_q[l] == MaxCnt) begin
                        ovf_d[l] = 1'b1;
                    end else begin
                        cnt_d[l] = cnt_q[l] + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (cnt_q[l] == '0) begin
                        unf_d[l] = 1'b1;
                    end else begin
                        cnt_d[l] = cnt_q[l] - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            cnt_q <= '0;
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign outstanding   = cnt_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

`ifdef NOC_LINK_STATS_EN
    // ------------------------------------------------------------------
    // Per-lane statistics, counted on the delayed (downstream) side
    // ------------------------------------------------------------------
    logic [NUM_LINKS-1:0][31:0] flit_cnt_q, flit_cnt_d;
    logic [NUM_LINKS-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        for (int unsigned l = 0; l < NUM_LINKS; l++) begin
            if (stats_clear) begin
                flit_cnt_d[l] = '0;
                pkt_cnt_d[l]  = '0;
            end else begin
                if (send_out[l]) begin
                    flit_cnt_d[l] = flit_cnt_q[l] + 32'd1;
                end
                if (send_out[l] && is_tail_out[l]) begin
                    pkt_cnt_d[l] = pkt_cnt_q[l] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign flit_count = flit_cnt_q;
    assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_noc_credit_link_pipeline.sv
// Randomized bench for noc_credit_link_pipeline; expected outputs come from a per-cycle
// history queue and integer counter model.
module tb_noc_credit_link_pipeline;

    localparam int unsigned NL    = 4;
    localparam int unsigned FW    = 64;
    localparam int unsigned DW    = 6;
    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic                       clk_noc = 1'b0;
    logic                       rst_noc_sync;
    logic [NL-1:0][FW-1:0]      data_in, data_out;
    logic [NL-1:0][DW-1:0]      dest_in, dest_out;
    logic [NL-1:0]              is_tail_in, is_tail_out;
    logic [NL-1:0]              send_in, send_out;
    logic [NL-1:0]              credit_in, credit_out;
    logic [NL-1:0][CW-1:0]      outstanding;
    logic [NL-1:0]              err_overflow, err_underflow;
`ifdef NOC_LINK_STATS_EN
    logic                       stats_clear;
    logic [NL-1:0][31:0]        flit_count, pkt_count;
    logic [31:0]                m_flit[NL];
    logic [31:0]                m_pkt[NL];
`endif

    always #5 clk_noc = ~clk_noc;

    noc_credit_link_pipeline #(
        .NUM_LINKS        (NL),
        .FLIT_WIDTH       (FW),
        .DEST_WIDTH       (DW),
        .NUM_PIPELINE     (NP),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .data_out     (data_out),
        .dest_out     (dest_out),
        .is_tail_out  (is_tail_out),
        .send_out     (send_out),
        .credit_in    (credit_in),
`ifdef NOC_LINK_STATS_EN
        .stats_clear  (stats_clear),
        .flit_count   (flit_count),
        .pkt_count    (pkt_count),
`endif
        .outstanding  (outstanding),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    typedef struct {
        logic [NL-1:0][FW-1:0] data;
        logic [NL-1:0][DW-1:0] dest;
        logic [NL-1:0]         tail;
        logic [NL-1:0]         send;
        logic [NL-1:0]         credit;
    } beat_t;

    // hist holds the inputs of the last NP cycles plus the current one; front is what exits now.
    beat_t       hist[$];
    int          m_os[NL];
    logic [NL-1:0] m_ovf, m_unf;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t zero_beat();
        beat_t b;
        b.data = '0; b.dest = '0; b.tail = '0; b.send = '0; b.credit = '0;
        return b;
    endfunction

    function automatic beat_t rand_beat(input int ps, input int pc);
        beat_t b;
        for (int l = 0; l < NL; l++) begin
            b.data[l]   = {$urandom, $urandom};
            b.dest[l]   = DW'($urandom);
            b.tail[l]   = $urandom_range(2) == 0;
            b.send[l]   = int'($urandom_range(99)) < ps;
            b.credit[l] = int'($urandom_range(99)) < pc;
        end
        return b;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NP; i++) hist.push_back(zero_beat());
        for (int l = 0; l < NL; l++) begin
            m_os[l] = 0;
`ifdef NOC_LINK_STATS_EN
            m_flit[l] = '0;
            m_pkt[l]  = '0;
`endif
        end
        m_ovf = '0;
        m_unf = '0;
    endtask

    // One clock cycle: apply b (with optional reset), check outputs, advance the model.
    task automatic step(input beat_t b, input bit rst, input bit clr);
        beat_t e;
        logic [NL-1:0][CW-1:0] eo;
        @(posedge clk_noc);
        #1;
        rst_noc_sync = rst;
        data_in      = b.data;
        dest_in      = b.dest;
        is_tail_in   = b.tail;
        send_in      = b.send;
        credit_in    = b.credit;
`ifdef NOC_LINK_STATS_EN
        stats_clear  = clr;
`endif
        hist.push_back(b);
        #3;
        e = hist.pop_front();
        for (int l = 0; l < NL; l++) begin
            eo[l] = CW'(m_os[l]);
            check_eq($sformatf("data_out[%0d]", l), data_out[l], e.data[l]);
        end
        check_eq("send_out", 64'(send_out), 64'(e.send));
        check_eq("credit_out", 64'(credit_out), 64'(e.credit));
        check_eq("dest_out", 64'(dest_out), 64'(e.dest));
        check_eq("is_tail_out", 64'(is_tail_out), 64'(e.tail));
        check_eq("outstanding", 64'(outstanding), 64'(eo));
        check_eq("err_overflow", 64'(err_overflow), 64'(m_ovf));
        check_eq("err_underflow", 64'(err_underflow), 64'(m_unf));
`ifdef NOC_LINK_STATS_EN
        for (int l = 0; l < NL; l++) begin
            check_eq($sformatf("flit_count[%0d]", l), 64'(flit_count[l]), 64'(m_flit[l]));
            check_eq($sformatf("pkt_count[%0d]", l), 64'(pkt_count[l]), 64'(m_pkt[l]));
        end
`endif
        if (rst) begin
            model_reset();
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (b.send[l] && !e.credit[l]) begin
                    if (m_os[l] == int'(DEPTH)) m_ovf[l] = 1'b1;
                    else m_os[l]++;
                end else if (!b.send[l] && e.credit[l]) begin
                    if (m_os[l] == 0) m_unf[l] = 1'b1;
                    else m_os[l]--;
                end
`ifdef NOC_LINK_STATS_EN
                if (clr) begin
                    m_flit[l] = '0;
                    m_pkt[l]  = '0;
                end else begin
                    m_flit[l] = m_flit[l] + 32'(e.send[l]);
                    m_pkt[l]  = m_pkt[l] + 32'(e.send[l] & e.tail[l]);
                end
`endif
            end
        end
    endtask

    initial begin
        beat_t b;
        rst_noc_sync = 1'b1;
        data_in = '0; dest_in = '0; is_tail_in = '0; send_in = '0; credit_in = '0;
`ifdef NOC_LINK_STATS_EN
        stats_clear = 1'b0;
`endif
        repeat (2) @(posedge clk_noc);
        model_reset();

        // Single flit on lane 1; other lanes must stay idle while it travels.
        for (int i = 0; i < 10; i++) step(zero_beat(), 1'b0, 1'b0);
        b = zero_beat();
        b.send[1] = 1'b1;
        b.data[1] = 64'hDEAD_BEEF;
        step(b, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(zero_beat(), 1'b0, 1'b0);

        // Back-to-back sends without credits drive every lane into overflow.
        for (int i = 0; i < 20; i++) step(rand_beat(90, 0), 1'b0, 1'b0);
        // Credits only: drain and then underflow.
        for (int i = 0; i < 30; i++) step(rand_beat(0, 60), 1'b0, 1'b0);

        // Reset with flits in flight, then quiet cycles.
        step(rand_beat(100, 0), 1'b0, 1'b0);
        step(rand_beat(100, 0), 1'b0, 1'b0);
        step(rand_beat(100, 100), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(zero_beat(), 1'b0, 1'b0);

        // Mixed traffic with occasional resets and stats clears.
        for (int i = 0; i < 800; i++) begin
            step(rand_beat(50, 45), $urandom_range(149) == 0, $urandom_range(39) == 0);
        end
        for (int i = 0; i < 300; i++) begin
            step(rand_beat(30, 30), 1'b0, $urandom_range(99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
